comp2bit_sweep_checker: RTL and testbench

//   Self-test sequencer for the 2-bit magnitude comparator. Drives the operand pair a/b and checks
//   the comparator's 3-bit result z = {eq, gt, lt}, sweeping all 16 operand pairs.

---
 rtl/comp2bit_sweep_checker.sv | 110 +++++++++++
 tb/tb_comp2bit_sweep_checker.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/comp2bit_sweep_checker.sv
// Self-test sequencer for a 2-bit magnitude comparator: sweeps all 16 {a,b} pairs and checks z={eq,gt,lt}.
// A full sweep takes 16*(SETTLE_CYCLES+1) cycles from start; start is ignored while busy.
module comp2bit_sweep_checker #(
  parameter int SETTLE_CYCLES = 1,
  parameter bit STOP_ON_FAIL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [1:0] a,
  output logic [1:0] b,
  input  logic [2:0] z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic [3:0] first_fail,
  output logic [2:0] first_fail_z,
  output logic       onehot_err
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     r_state;
  logic [3:0] r_vec;
  logic [7:0] r_settle;

  logic [2:0] w_exp;
  logic       w_onehot;
  logic       w_mismatch;
  logic [4:0] w_err_nxt;

  // z is sampled straight off the comparator; the DRIVE settle window covers its delay.
  assign w_exp      = {a == b, a > b, a < b};
  assign w_onehot   = (z == 3'b001) || (z == 3'b010) || (z == 3'b100);
  assign w_mismatch = (z != w_exp);
  assign w_err_nxt  = err_cnt + 5'(w_mismatch);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_vec        <= 4'd0;
      r_settle     <= 8'd0;
      a            <= 2'd0;
      b            <= 2'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_cnt      <= 5'd0;
      first_fail   <= 4'd0;
      first_fail_z <= 3'd0;
      onehot_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state      <= S_DRIVE;
            r_vec        <= 4'd0;
            r_settle     <= 8'd0;
            a            <= 2'd0;
            b            <= 2'd0;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_cnt      <= 5'd0;
            first_fail   <= 4'd0;
            first_fail_z <= 3'd0;
            onehot_err   <= 1'b0;
          end
        end
        S_DRIVE: begin
          if (r_settle == SETTLE_LAST) begin
            r_state  <= S_CHECK;
            r_settle <= 8'd0;
          end else begin
            r_settle <= r_settle + 8'd1;
          end
        end
        S_CHECK: begin
          if (w_mismatch) begin
            err_cnt <= w_err_nxt;
            if (err_cnt == 5'd0) begin
              first_fail   <= {a, b};
              first_fail_z <= z;
            end
          end
          if (!w_onehot) begin
            onehot_err <= 1'b1;
          end
          if ((r_vec == 4'd15) || (STOP_ON_FAIL && w_mismatch)) begin
            r_state <= S_DONE;
            a       <= 2'd0;
            b       <= 2'd0;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (w_err_nxt == 5'd0);
          end else begin
            r_state <= S_DRIVE;
            r_vec   <= r_vec + 4'd1;
            {a, b}  <= r_vec + 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comp2bit_sweep_checker.sv
// Directed bench: three checker instances (S=1, S=1 stop-on-fail, S=3) driven by selectable comparator models.
module tb_comp2bit_sweep_checker;

  logic       clk;
  logic       rst_n;
  logic       start_v      [3];
  int         mode_v       [3];
  logic [1:0] a_v          [3];
  logic [1:0] b_v          [3];
  logic [2:0] z_v          [3];
  logic       busy_v       [3];
  logic       done_v       [3];
  logic       pass_v       [3];
  logic [4:0] err_v        [3];
  logic [3:0] ff_v         [3];
  logic [2:0] ffz_v        [3];
  logic       onehot_v     [3];

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode 0 ideal, 1 stuck 100, 2 stuck 000, 3 gt/lt swapped
  function automatic logic [2:0] model_z(input int m, input logic [1:0] x, input logic [1:0] y);
    logic [2:0] ideal;
    ideal = {x == y, x > y, x < y};
    case (m)
      1:       return 3'b100;
      2:       return 3'b000;
      3:       return {ideal[2], ideal[0], ideal[1]};
      default: return ideal;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int S   = (g == 2) ? 3 : 1;
    localparam bit SOF = (g == 1);
    comp2bit_sweep_checker #(.SETTLE_CYCLES(S), .STOP_ON_FAIL(SOF)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start_v[g]),
      .a            (a_v[g]),
      .b            (b_v[g]),
      .z            (z_v[g]),
      .busy         (busy_v[g]),
      .done         (done_v[g]),
      .pass         (pass_v[g]),
      .err_cnt      (err_v[g]),
      .first_fail   (ff_v[g]),
      .first_fail_z (ffz_v[g]),
      .onehot_err   (onehot_v[g])
    );
    assign z_v[g] = model_z(mode_v[g], a_v[g], b_v[g]);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input int g);
    start_v[g] = 1'b1;
    @(posedge clk);
    #1;
    start_v[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, output int n);
    n = 0;
    while (!done_v[g] && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      start_v[g] = 1'b0;
      mode_v[g]  = 0;
    end
    #3;
    check("rst_ab",     32'({a_v[0], b_v[0]}), 32'd0);
    check("rst_busy",   32'(busy_v[0]),        32'd0);
    check("rst_done",   32'(done_v[0]),        32'd0);
    check("rst_pass",   32'(pass_v[0]),        32'd0);
    check("rst_err",    32'(err_v[0]),         32'd0);
    check("rst_ff",     32'({ff_v[0], ffz_v[0]}), 32'd0);
    check("rst_onehot", 32'(onehot_v[0]),      32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_busy", 32'(busy_v[0]), 32'd0);

    // 1: ideal comparator, a/b stepping every S+1 cycles
    pulse_start(0);
    for (int k = 0; k < 16; k++) begin
      check("t1_ab",   32'({a_v[0], b_v[0]}), 32'(k));
      check("t1_busy", 32'(busy_v[0]), 32'd1);
      if (k == 15) check("t1_notdone", 32'(done_v[0]), 32'd0);
      repeat (2) @(posedge clk);
      #1;
    end
    check("t1_done",   32'(done_v[0]),   32'd1);
    check("t1_pass",   32'(pass_v[0]),   32'd1);
    check("t1_err",    32'(err_v[0]),    32'd0);
    check("t1_onehot", 32'(onehot_v[0]), 32'd0);
    check("t1_ab0",    32'({a_v[0], b_v[0]}), 32'd0);
    check("t1_busy0",  32'(busy_v[0]),   32'd0);

    // 2: z stuck at eq
    mode_v[0] = 1;
    pulse_start(0);
    wait_done(0, cyc);
    check("t2_lat",    32'(cyc),         32'd32);
    check("t2_err",    32'(err_v[0]),    32'd12);
    check("t2_ff",     32'(ff_v[0]),     32'h1);
    check("t2_ffz",    32'(ffz_v[0]),    32'h4);
    check("t2_onehot", 32'(onehot_v[0]), 32'd0);
    check("t2_pass",   32'(pass_v[0]),   32'd0);

    // 3: z stuck at 000
    mode_v[0] = 2;
    pulse_start(0);
    wait_done(0, cyc);
    check("t3_lat",    32'(cyc),         32'd32);
    check("t3_err",    32'(err_v[0]),    32'd16);
    check("t3_onehot", 32'(onehot_v[0]), 32'd1);
    check("t3_ff",     32'(ff_v[0]),     32'h0);
    check("t3_ffz",    32'(ffz_v[0]),    32'h0);
    check("t3_pass",   32'(pass_v[0]),   32'd0);

    // 4: stop on first fail, gt/lt swapped
    mode_v[1] = 3;
    pulse_start(1);
    wait_done(1, cyc);
    check("t4_lat",  32'(cyc),       32'd4);
    check("t4_err",  32'(err_v[1]),  32'd1);
    check("t4_ff",   32'(ff_v[1]),   32'h1);
    check("t4_ffz",  32'(ffz_v[1]),  32'h2);
    check("t4_pass", 32'(pass_v[1]), 32'd0);

    // 5: reset mid-sweep during vector 7
    mode_v[0] = 1;
    pulse_start(0);
    repeat (14) @(posedge clk);
    #1;
    check("t5_ab7",  32'({a_v[0], b_v[0]}), 32'd7);
    check("t5_err5", 32'(err_v[0]), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_ab",   32'({a_v[0], b_v[0]}), 32'd0);
    check("t5_busy", 32'(busy_v[0]), 32'd0);
    check("t5_err",  32'(err_v[0]),  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mode_v[0] = 0;
    pulse_start(0);
    wait_done(0, cyc);
    check("t5_lat",  32'(cyc),       32'd32);
    check("t5_pass", 32'(pass_v[0]), 32'd1);
    check("t5_err2", 32'(err_v[0]),  32'd0);

    // 6: S=3, start while busy ignored, start held through DONE
    mode_v[2] = 1;
    pulse_start(2);
    repeat (5) @(posedge clk);
    #1;
    start_v[2] = 1'b1;
    @(posedge clk);
    #1;
    start_v[2] = 1'b0;
    check("t6_ab_busy", 32'({a_v[2], b_v[2]}), 32'd1);
    check("t6_busy",    32'(busy_v[2]), 32'd1);
    repeat (54) @(posedge clk);
    #1;
    start_v[2] = 1'b1;
    wait_done(2, cyc);
    check("t6_lat",  32'(cyc),       32'd4);
    check("t6_err",  32'(err_v[2]),  32'd12);
    @(posedge clk);
    #1;
    start_v[2] = 1'b0;
    check("t6_rl_done", 32'(done_v[2]), 32'd0);
    check("t6_rl_busy", 32'(busy_v[2]), 32'd1);
    check("t6_rl_err",  32'(err_v[2]),  32'd0);
    check("t6_rl_ff",   32'(ff_v[2]),   32'd0);
    check("t6_rl_ab",   32'({a_v[2], b_v[2]}), 32'd0);
    wait_done(2, cyc);
    check("t6_lat2",  32'(cyc),       32'd64);
    check("t6_err2",  32'(err_v[2]),  32'd12);
    check("t6_ff2",   32'(ff_v[2]),   32'h1);
    check("t6_pass2", 32'(pass_v[2]), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
